// File: rtl/bfm_dispatch_pkg.sv
// Shared types and defaults for the multi-buffer descriptor dispatch unit.
// Holds the FSM state encoding, parameter defaults and the one-hot helper.
// No logic of its own; imported by the top and the beat packer.
package bfm_dispatch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    localparam int DEF_NUM_BUFFERS  = 2;
    localparam int DEF_ELEM_W       = 8;
    localparam int DEF_LANES        = 4;
    localparam int DEF_BEATS_PER_KP = 8;
    localparam int DEF_CELL_ID_W    = 8;
    localparam int DEF_CNT_W        = 16;

    // True when exactly one bit is set; zero is not one-hot.
    function automatic logic is_onehot(input logic [31:0] v);
        return (v != 32'd0) && ((v & (v - 32'd1)) == 32'd0);
    endfunction

endpackage

// File: rtl/bfm_dispatch_beat_packer.sv
// Beat packer: keeps the even-slot elements of each accepted beat in a slot array.
// Latency: a beat accepted at edge N is visible on kp_dat after that edge.
// No backpressure of its own; the parent only asserts beat_vld when it accepts a beat.
module bfm_dispatch_beat_packer
    import bfm_dispatch_pkg::*;
#(
    parameter int ELEM_W       = DEF_ELEM_W,
    parameter int LANES        = DEF_LANES,
    parameter int BEATS_PER_KP = DEF_BEATS_PER_KP,
    parameter int CELL_ID_W    = DEF_CELL_ID_W
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   beat_vld,
    input  logic [2*LANES*ELEM_W-1:0]              beat_raw,
    input  logic [CELL_ID_W-1:0]                   beat_cell_id,
    input  logic                                   clr,
    output logic                                   last_beat,
    output logic [BEATS_PER_KP*LANES*ELEM_W-1:0]   kp_dat,
    output logic [CELL_ID_W-1:0]                   kp_cell_id
);

    localparam int BEAT_W = LANES * ELEM_W;
    localparam int IDX_W  = (BEATS_PER_KP > 1) ? $clog2(BEATS_PER_KP) : 1;

    logic [BEATS_PER_KP-1:0][BEAT_W-1:0] slot_q;
    logic [IDX_W-1:0]                    idx_q;
    logic [CELL_ID_W-1:0]                cell_id_q;
    logic [BEAT_W-1:0]                   packed_beat;
    logic [BEAT_W-1:0]                   odd_elems;
    logic                                unused_odd;

    // Element i of the beat comes from raw slot 2i; odd slots carry nothing we keep.
    always_comb begin
        packed_beat = '0;
        odd_elems   = '0;
        for (int i = 0; i < LANES; i++) begin
            packed_beat[i*ELEM_W +: ELEM_W] = beat_raw[(2*i)*ELEM_W +: ELEM_W];
            odd_elems[i*ELEM_W +: ELEM_W]   = beat_raw[(2*i+1)*ELEM_W +: ELEM_W];
        end
    end

    assign unused_odd = ^odd_elems;
    assign last_beat  = (idx_q == IDX_W'(BEATS_PER_KP - 1));
    assign kp_dat     = slot_q;
    assign kp_cell_id = cell_id_q;

    // Slot write, beat index advance (wraps to 0 after the last beat) and beat-0 cell ID capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            slot_q    <= '0;
            idx_q     <= '0;
            cell_id_q <= '0;
        end else if (clr) begin
            idx_q <= '0;
        end else if (beat_vld) begin
            slot_q[idx_q] <= packed_beat;
            if (idx_q == '0) begin
                cell_id_q <= beat_cell_id;
            end
            idx_q <= last_beat ? '0 : idx_q + IDX_W'(1);
        end
    end

endmodule

// File: rtl/bfm_multi_buffer_dispatch_unit.sv
// Dispatch unit: packs BEATS_PER_KP input beats per keypoint and hands each keypoint to one buffer.
// Latency: out_valid rises 1 cycle after the last beat; done/err pulse 1 cycle after their cause.
// Backpressure: in_ready is low outside LOAD; a keypoint is held stable until out_ready[sel].
// Optional stall statistics counter enabled by macro BFM_DISPATCH_STATS_EN.
module bfm_multi_buffer_dispatch_unit
    import bfm_dispatch_pkg::*;
#(
    parameter int                     NUM_BUFFERS  = DEF_NUM_BUFFERS,
    parameter int                     ELEM_W       = DEF_ELEM_W,
    parameter int                     LANES        = DEF_LANES,
    parameter int                     BEATS_PER_KP = DEF_BEATS_PER_KP,
    parameter int                     CELL_ID_W    = DEF_CELL_ID_W,
    parameter int                     CNT_W        = DEF_CNT_W,
    parameter logic [NUM_BUFFERS-1:0] CELL_ID_MASK = NUM_BUFFERS'(2'b10)
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   in_valid,
    output logic                                   in_ready,
    input  logic [2*LANES*ELEM_W-1:0]              in_data,
    input  logic [CELL_ID_W-1:0]                   in_cell_id,
    input  logic                                   start,
    input  logic [NUM_BUFFERS-1:0]                 buf_sel,
    input  logic [CNT_W-1:0]                       kp_count,
    output logic                                   busy,
    output logic [CNT_W-1:0]                       load_cnt,
    output logic [BEATS_PER_KP*LANES*ELEM_W-1:0]   out_data,
    output logic [CELL_ID_W-1:0]                   out_cell_id,
    output logic [NUM_BUFFERS-1:0]                 out_valid,
    input  logic [NUM_BUFFERS-1:0]                 out_ready,
    output logic                                   done,
    output logic                                   err,
    output logic [31:0]                            stall_cycles
);

    state_t                 state_q, state_d;
    logic [NUM_BUFFERS-1:0] sel_q;
    logic [CNT_W-1:0]       remaining_q;
    logic [CNT_W-1:0]       load_cnt_q;
    logic                   done_q;
    logic                   err_q;

    logic                   sel_onehot;
    logic                   start_go;
    logic                   beat_acc;
    logic                   sel_ready;
    logic                   handoff;
    logic                   last_beat;
    logic [CELL_ID_W-1:0]   kp_cell_id;
    logic                   mask_hit;

    assign sel_onehot = is_onehot(32'(buf_sel));
    assign start_go   = (state_q == ST_IDLE) && start && sel_onehot && (kp_count != '0);
    assign beat_acc   = in_valid && in_ready;
    // Only the ready bit of the latched buffer matters; the others are ignored.
    assign sel_ready  = |(out_ready & sel_q);
    assign handoff    = (state_q == ST_HOLD) && sel_ready;
    assign mask_hit   = |(CELL_ID_MASK & sel_q);

    bfm_dispatch_beat_packer #(
        .ELEM_W       (ELEM_W),
        .LANES        (LANES),
        .BEATS_PER_KP (BEATS_PER_KP),
        .CELL_ID_W    (CELL_ID_W)
    ) u_packer (
        .clk          (clk),
        .rst          (rst),
        .beat_vld     (beat_acc),
        .beat_raw     (in_data),
        .beat_cell_id (in_cell_id),
        .clr          (start_go),
        .last_beat    (last_beat),
        .kp_dat       (out_data),
        .kp_cell_id   (kp_cell_id)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and state-decoded handshake outputs.
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = '0;
        case (state_q)
            ST_IDLE: begin
                if (start_go) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                in_ready = 1'b1;
                if (beat_acc && last_beat) begin
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                out_valid = sel_q;
                if (handoff) begin
                    state_d = (remaining_q == CNT_W'(1)) ? ST_IDLE : ST_LOAD;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Load bookkeeping: latch on legal start, count down handoffs, one-cycle done/err pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            sel_q       <= '0;
            remaining_q <= '0;
            load_cnt_q  <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            if ((state_q == ST_IDLE) && start) begin
                if (!sel_onehot) begin
                    err_q <= 1'b1;
                end else if (kp_count == '0) begin
                    done_q <= 1'b1;
                end else begin
                    sel_q       <= buf_sel;
                    load_cnt_q  <= kp_count;
                    remaining_q <= kp_count;
                end
            end
            if (handoff) begin
                remaining_q <= remaining_q - CNT_W'(1);
                if (remaining_q == CNT_W'(1)) begin
                    done_q <= 1'b1;
                end
            end
        end
    end

    assign busy        = (state_q != ST_IDLE);
    assign load_cnt    = load_cnt_q;
    assign done        = done_q;
    assign err         = err_q;
    assign out_cell_id = mask_hit ? kp_cell_id : '0;

`ifdef BFM_DISPATCH_STATS_EN
    logic [31:0] stall_q;

    // Count HOLD cycles where the selected buffer refuses the keypoint; saturating.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= '0;
        end else if (start_go) begin
            stall_q <= '0;
        end else if ((state_q == ST_HOLD) && !sel_ready && (stall_q != '1)) begin
            stall_q <= stall_q + 32'd1;
        end
    end

    assign stall_cycles = stall_q;
`else
    assign stall_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_bfm_multi_buffer_dispatch_unit.sv
// Bench for the dispatch unit: a default-parameter instance and a 4-buffer/2-lane/16-beat instance.
// Stimulus pushes expected keypoints into queues; negedge monitors pop and compare on each handoff.
// Control pulses and counters are checked directly against hand-derived values.
module tb_bfm_multi_buffer_dispatch_unit;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

`ifdef BFM_DISPATCH_STATS_EN
    localparam logic [31:0] EXP_STALL = 32'd5;
`else
    localparam logic [31:0] EXP_STALL = 32'd0;
`endif

    // ---------------- instance A: defaults ----------------
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [63:0]  in_data = '0;
    logic [7:0]   in_cell_id = '0;
    logic         start = 1'b0;
    logic [1:0]   buf_sel = '0;
    logic [15:0]  kp_count = '0;
    logic         busy;
    logic [15:0]  load_cnt;
    logic [255:0] out_data;
    logic [7:0]   out_cell_id;
    logic [1:0]   out_valid;
    logic [1:0]   out_ready = '0;
    logic         done;
    logic         err;
    logic [31:0]  stall_cycles;

    bfm_multi_buffer_dispatch_unit dut_a (
        .clk (clk), .rst (rst),
        .in_valid (in_valid), .in_ready (in_ready), .in_data (in_data), .in_cell_id (in_cell_id),
        .start (start), .buf_sel (buf_sel), .kp_count (kp_count),
        .busy (busy), .load_cnt (load_cnt),
        .out_data (out_data), .out_cell_id (out_cell_id), .out_valid (out_valid), .out_ready (out_ready),
        .done (done), .err (err), .stall_cycles (stall_cycles)
    );

    // ---------------- instance B: 4 buffers, 2 lanes, 16 beats ----------------
    logic         b_in_valid = 1'b0;
    logic         b_in_ready;
    logic [31:0]  b_in_data = '0;
    logic [7:0]   b_in_cell_id = '0;
    logic         b_start = 1'b0;
    logic [3:0]   b_buf_sel = '0;
    logic [15:0]  b_kp_count = '0;
    logic         b_busy;
    logic [15:0]  b_load_cnt;
    logic [255:0] b_out_data;
    logic [7:0]   b_out_cell_id;
    logic [3:0]   b_out_valid;
    logic [3:0]   b_out_ready = '0;
    logic         b_done;
    logic         b_err;
    logic [31:0]  b_stall_cycles;

    bfm_multi_buffer_dispatch_unit #(
        .NUM_BUFFERS (4), .LANES (2), .BEATS_PER_KP (16)
    ) dut_b (
        .clk (clk), .rst (rst),
        .in_valid (b_in_valid), .in_ready (b_in_ready), .in_data (b_in_data), .in_cell_id (b_in_cell_id),
        .start (b_start), .buf_sel (b_buf_sel), .kp_count (b_kp_count),
        .busy (b_busy), .load_cnt (b_load_cnt),
        .out_data (b_out_data), .out_cell_id (b_out_cell_id), .out_valid (b_out_valid), .out_ready (b_out_ready),
        .done (b_done), .err (b_err), .stall_cycles (b_stall_cycles)
    );

    typedef struct packed {
        logic [3:0]   vld;
        logic [255:0] dat;
        logic [7:0]   cid;
    } exp_t;

    exp_t a_q[$];
    exp_t b_q[$];
    int   done_seen = 0;
    int   err_seen = 0;
    int   b_done_seen = 0;
    int   b_err_seen = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    // Element values: distinct per keypoint/beat/lane; odd raw slots carry the inverse as decoys.
    function automatic logic [7:0] elem_a(input int tag, input int b, input int i);
        return 8'(tag * 32 + b * 4 + i + 3);
    endfunction

    function automatic logic [255:0] exp_a(input int tag);
        logic [255:0] v = '0;
        for (int b = 0; b < 8; b++)
            for (int i = 0; i < 4; i++)
                v[(b*4+i)*8 +: 8] = elem_a(tag, b, i);
        return v;
    endfunction

    function automatic logic [7:0] elem_b(input int b, input int i);
        return 8'(100 + b * 2 + i);
    endfunction

    function automatic logic [255:0] exp_b();
        logic [255:0] v = '0;
        for (int b = 0; b < 16; b++)
            for (int i = 0; i < 2; i++)
                v[(b*2+i)*8 +: 8] = elem_b(b, i);
        return v;
    endfunction

    // Monitor for instance A: counts pulses, checks each handoff against the queue.
    always @(negedge clk) begin : mon_a
        exp_t e;
        if (!rst) begin
            if (done) done_seen++;
            if (err) err_seen++;
            if ((out_valid & out_ready) != 2'b00) begin
                if (a_q.size() == 0) begin
                    timeout_fail("a_unexpected_handoff");
                end else begin
                    e = a_q.pop_front();
                    chk("a_out_valid", out_valid, e.vld[1:0]);
                    chk("a_out_data", out_data, e.dat);
                    chk("a_out_cell_id", out_cell_id, e.cid);
                end
            end
        end
    end

    // Monitor for instance B: any raised out_valid must be the expected keypoint on buffer 2.
    always @(negedge clk) begin : mon_b
        exp_t e;
        if (!rst) begin
            if (b_done) b_done_seen++;
            if (b_err) b_err_seen++;
            if (b_out_valid != 4'b0000) begin
                if (b_q.size() == 0) begin
                    timeout_fail("b_unexpected_valid");
                end else begin
                    e = b_q.pop_front();
                    chk("b_out_valid", b_out_valid, e.vld);
                    chk("b_out_data", b_out_data, e.dat);
                    chk("b_out_cell_id", b_out_cell_id, e.cid);
                end
            end
        end
    end

    // All stimulus tasks are entered just after a rising edge.
    task automatic pulse_start(input logic [1:0] sel, input logic [15:0] cnt);
        start = 1'b1;
        buf_sel = sel;
        kp_count = cnt;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send_a(input int tag, input logic [7:0] cid, input int nbeats);
        logic [63:0] raw;
        int n;
        for (int b = 0; b < nbeats; b++) begin
            raw = '0;
            for (int i = 0; i < 4; i++) begin
                raw[(2*i)*8 +: 8]   = elem_a(tag, b, i);
                raw[(2*i+1)*8 +: 8] = ~elem_a(tag, b, i);
            end
            in_valid = 1'b1;
            in_data = raw;
            in_cell_id = (b == 0) ? cid : (8'hF0 | 8'(b));
            n = 0;
            @(negedge clk);
            while (!in_ready && n < 200) begin
                @(negedge clk);
                n++;
            end
            if (!in_ready) timeout_fail("a_in_ready_wait");
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_idle_a();
        int n = 0;
        while (busy && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (busy) timeout_fail("a_idle_wait");
        @(posedge clk); #1;
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        exp_t e;
        logic [31:0] braw;
        int n;

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state.
        chk("rst_busy", busy, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_load_cnt", load_cnt, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_cell_id", out_cell_id, 0);
        chk("rst_done_err", {done, err}, 0);
        chk("rst_stall", stall_cycles, 0);

        // Three keypoints to buffer 0, which is outside the cell ID mask.
        out_ready = 2'b01;
        pulse_start(2'b01, 16'd3);
        chk("t1_busy", busy, 1);
        chk("t1_load_cnt", load_cnt, 3);
        pulse_start(2'b11, 16'd5);
        chk("t1_start_while_busy_err", err, 0);
        chk("t1_load_cnt_kept", load_cnt, 3);
        for (int k = 1; k <= 3; k++) begin
            e = '{vld: 4'b0001, dat: exp_a(k), cid: 8'h00};
            a_q.push_back(e);
        end
        for (int k = 1; k <= 3; k++) send_a(k, 8'h5A, 8);
        wait_idle_a();
        chk("t1_done_count", done_seen, 1);
        chk("t1_load_cnt_after", load_cnt, 3);

        // Two keypoints to buffer 1 (masked): cell IDs from beat 0 only.
        out_ready = 2'b10;
        pulse_start(2'b10, 16'd2);
        e = '{vld: 4'b0010, dat: exp_a(4), cid: 8'h11};
        a_q.push_back(e);
        e = '{vld: 4'b0010, dat: exp_a(5), cid: 8'h22};
        a_q.push_back(e);
        send_a(4, 8'h11, 8);
        send_a(5, 8'h22, 8);
        wait_idle_a();
        chk("t2_done_count", done_seen, 2);

        // Backpressure: buffer 1 refuses for 5 HOLD cycles while other ready bit and in_valid are high.
        out_ready = 2'b01;
        pulse_start(2'b10, 16'd1);
        e = '{vld: 4'b0010, dat: exp_a(6), cid: 8'h33};
        a_q.push_back(e);
        send_a(6, 8'h33, 8);
        in_valid = 1'b1;
        in_data = 64'hDEAD_BEEF_CAFE_F00D;
        in_cell_id = 8'h77;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("t3_in_ready_hold", in_ready, 0);
            chk("t3_out_valid_hold", out_valid, 2'b10);
            chk("t3_out_data_hold", out_data, exp_a(6));
        end
        @(posedge clk); #1;
        out_ready = 2'b10;
        wait_idle_a();
        in_valid = 1'b0;
        chk("t3_stall_cycles", stall_cycles, EXP_STALL);
        chk("t3_done_count", done_seen, 3);

        // Illegal starts and a zero-count start.
        pulse_start(2'b11, 16'd1);
        chk("t4_err_multi", err, 1);
        chk("t4_busy_multi", busy, 0);
        pulse_start(2'b00, 16'd1);
        chk("t4_err_zero_sel", err, 1);
        pulse_start(2'b01, 16'd0);
        chk("t4_done_zero_cnt", done, 1);
        chk("t4_busy_zero_cnt", busy, 0);
        @(posedge clk); #1;
        chk("t4_err_count", err_seen, 2);
        chk("t4_done_count", done_seen, 4);

        // Reset after 3 of 8 beats, then a fresh single-keypoint load.
        out_ready = 2'b01;
        pulse_start(2'b01, 16'd1);
        send_a(7, 8'h99, 3);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("t5_in_ready_after_rst", in_ready, 0);
        chk("t5_busy_after_rst", busy, 0);
        chk("t5_load_cnt_after_rst", load_cnt, 0);
        chk("t5_out_data_after_rst", out_data, 0);
        pulse_start(2'b01, 16'd1);
        e = '{vld: 4'b0001, dat: exp_a(8), cid: 8'h00};
        a_q.push_back(e);
        send_a(8, 8'h44, 8);
        wait_idle_a();
        chk("t5_done_count", done_seen, 5);

        // Wide configuration: only buffer 2 may raise out_valid.
        b_out_ready = 4'b1111;
        b_start = 1'b1;
        b_buf_sel = 4'b0100;
        b_kp_count = 16'd1;
        @(posedge clk); #1;
        b_start = 1'b0;
        e = '{vld: 4'b0100, dat: exp_b(), cid: 8'h00};
        b_q.push_back(e);
        for (int b = 0; b < 16; b++) begin
            braw = '0;
            for (int i = 0; i < 2; i++) begin
                braw[(2*i)*8 +: 8]   = elem_b(b, i);
                braw[(2*i+1)*8 +: 8] = ~elem_b(b, i);
            end
            b_in_valid = 1'b1;
            b_in_data = braw;
            b_in_cell_id = 8'h60 + 8'(b);
            n = 0;
            @(negedge clk);
            while (!b_in_ready && n < 200) begin
                @(negedge clk);
                n++;
            end
            if (!b_in_ready) timeout_fail("b_in_ready_wait");
            @(posedge clk); #1;
        end
        b_in_valid = 1'b0;
        n = 0;
        while (b_busy && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (b_busy) timeout_fail("b_idle_wait");
        @(posedge clk); #1;
        chk("b_done_count", b_done_seen, 1);
        chk("b_err_count", b_err_seen, 0);
        chk("b_load_cnt", b_load_cnt, 1);
        chk("b_stall_cycles", b_stall_cycles, 0);

        chk("a_queue_drained", a_q.size(), 0);
        chk("b_queue_drained", b_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bfm_multi_buffer_dispatch_unit.md
BFM_MULTI_BUFFER_DISPATCH_UNIT -- requirements
Module: bfm_multi_buffer_dispatch_unit

Interface
REQ-001 Parameter NUM_BUFFERS, default 2: number of descriptor buffer channels.
REQ-002 Parameter ELEM_W, default 8: descriptor element width in bits.
REQ-003 Parameter LANES, default 4: descriptor elements used per input beat.
REQ-004 Parameter BEATS_PER_KP, default 8: input beats per keypoint. SIMD = LANES*BEATS_PER_KP.
REQ-005 Parameter CELL_ID_W, default 8: cell ID width.
REQ-006 Parameter CNT_W, default 16: keypoint count width.
REQ-007 Parameter CELL_ID_MASK, default NUM_BUFFERS'b10: bit b set means buffer b receives the cell ID.
REQ-008 Ports, one per line:
 clk  in  1  clock.
 rst  in  1  reset; synchronous, active-high.
 in_valid  in  1  input beat valid.
 in_ready  out  1  input beat accepted when in_valid && in_ready.
 in_data  in  2*LANES*ELEM_W  raw beat; element i is taken from slot 2i.
 in_cell_id  in  CELL_ID_W  cell ID carried with each beat.
 start  in  1  begin a load; sampled in IDLE only.
 buf_sel  in  NUM_BUFFERS  one-hot target buffer.
 kp_count  in  CNT_W  number of keypoints to load.
 busy  out  1  high whenever state != IDLE.
 load_cnt  out  CNT_W  kp_count latched at start.
 out_data  out  SIMD*ELEM_W  assembled keypoint; beat k occupies bits [k*LANES*ELEM_W +: LANES*ELEM_W].
 out_cell_id  out  CELL_ID_W  cell ID of the keypoint's beat 0, or 0 if the mask bit is clear.
 out_valid  out  NUM_BUFFERS  per-buffer valid; only the latched buf_sel bit is ever high.
 out_ready  in  NUM_BUFFERS  per-buffer accept.
 done  out  1  one-cycle pulse at the end of a load.
 err  out  1  one-cycle pulse on an illegal start.
 stall_cycles  out  32  statistics counter (see REQ-027).

Function
REQ-009 States: IDLE, LOAD, HOLD.
REQ-010 IDLE -> LOAD on start with a one-hot buf_sel and kp_count != 0. The transition latches buf_sel, kp_count into load_cnt, and remaining = kp_count, and clears the beat index.
REQ-011 start with kp_count == 0 and a one-hot buf_sel: done pulses the next cycle and the state stays IDLE.
REQ-012 start with buf_sel not one-hot (zero or multi-bit): err pulses the next cycle, the state stays IDLE, and no latch occurs.
REQ-013 in_ready = (state == LOAD); it is combinational from state only.
REQ-014 Accepted beat: written to beat slot beat_idx, beat_idx increments, and in_cell_id is captured when beat_idx == 0.
REQ-015 The last beat (beat_idx == BEATS_PER_KP-1) moves to HOLD the next cycle.
- In HOLD, out_valid[sel] is high and beat_idx is 0.
- Latency from the last accepted beat to out_valid is 1 cycle.
REQ-016 HOLD: out_data and out_cell_id are stable while out_valid && !out_ready[sel]; in_ready stays low.
REQ-017 Handoff (out_valid[sel] && out_ready[sel]) decrements remaining.
- remaining becomes 0: go to IDLE and pulse done in the same cycle.
- otherwise: go to LOAD.
REQ-018 out_ready bits other than sel are ignored. in_valid while in_ready is low is ignored; no beat is lost or duplicated.
REQ-019 start while busy is ignored (no err).
REQ-020 load_cnt holds its value until the next legal start.
REQ-021 All arithmetic is unsigned. remaining never underflows; the IDLE entry condition guarantees remaining >= 1.

Reset
REQ-022 rst forces state IDLE, beat_idx 0, remaining 0, load_cnt 0, latched sel 0, out_valid 0, done 0, err 0, stall_cycles 0; out_data and out_cell_id are 0.
REQ-023 rst mid-LOAD or mid-HOLD aborts the load: partial beats are discarded, there is no done pulse, and in_ready is 0 the cycle after rst.

Configuration
REQ-024 Macro BFM_DISPATCH_STATS_EN.
REQ-025 Defined: stall_cycles increments each HOLD cycle with out_ready[sel] low. It saturates at all-ones and clears on a legal start.
REQ-026 Undefined: stall_cycles is tied to 0 and no counter logic exists.
REQ-027 Port list is identical in both cases.

Structure
REQ-028 Package bfm_dispatch_pkg holds the state enum, parameter defaults and the is_onehot function.
REQ-029 Sub-module bfm_dispatch_beat_packer holds the beat slot register array, beat_idx and the cell ID capture. The FSM, counters and handshake stay at top level.

Verification
REQ-030 Defaults, start, buf_sel=2'b01, kp_count=3, 24 beats, out_ready=1 -> three out_valid[0] pulses; out_cell_id=0; done after the third handoff; load_cnt=3.
REQ-031 buf_sel=2'b10, kp_count=2, beat-0 cell IDs 0x11 and 0x22 -> out_cell_id 0x11 then 0x22; beat k data matches in_data even slots.
REQ-032 out_ready[1] low 5 cycles in HOLD with in_valid held high -> in_ready=0 and data stable for 5 cycles; stall_cycles=5 with STATS_EN, 0 without.
REQ-033 start with buf_sel=2'b11 -> err pulse, busy=0; start with buf_sel=2'b01 and kp_count=0 -> done pulse, busy=0.
REQ-034 rst asserted after 3 of 8 beats, then a new load with kp_count=1 -> no done before rst; the new keypoint contains only the new beats.
REQ-035 NUM_BUFFERS=4, LANES=2, BEATS_PER_KP=16, buf_sel=4'b0100 -> only out_valid[2] toggles; out_data width is 256.
